// File: rtl/riscv_mc_controller_if.sv
// Control bus between the multicycle RISC-V datapath and its controller.
// The datapath supplies instruction fields and status; the controller drives strobes.
interface riscv_mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic [3:0] State;

    // Datapath side: provides instruction fields and status, consumes controls.
    modport master (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
    );

    // Controller side.
    modport slave (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
    );
endinterface

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute,
// ALU decoder and immediate-format decoder. Write strobes are forced low
// while reset is held so an aborted instruction never commits anything.
module riscv_mc_controller (
    input  logic                        clk,
    input  logic                        reset,
    riscv_mc_controller_if.slave        bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t     state_reg;
    state_t     state_next;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic [2:0] alu_control;
    logic [1:0] imm_src;

    // State register; reset returns to FETCH immediately, without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-state control decode; strobes masked while reset is low.
    always_comb begin
        state_next = state_reg;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // Instruction word and PC+4 only commit once memory delivers.
                if (bus.MemReady) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD,
                    OP_STORE:  state_next = S_MEMADR;
                    OP_RTYPE:  state_next = S_EXECR;
                    OP_ITYPE:  state_next = S_EXECI;
                    OP_JAL:    state_next = S_JAL;
                    OP_BRANCH: state_next = S_BRANCH;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.MemReady) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.MemReady) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                // funct3[0] distinguishes bne from beq.
                pc_write   = bus.Zero ^ bus.funct3[0];
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (!reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    // ALU decoder: sub only for R-type with funct7b5, since addi has no sub form.
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Immediate format select, valid in every state.
    always_comb begin
        imm_src = 2'b00;
        case (bus.op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;
    assign bus.Illegal    = illegal;
    assign bus.State      = state_reg;

endmodule

// File: doc/riscv_mc_controller.md
RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs op[6:0], funct3[2:0] and funct7b5 (1 bit), all taken from the instruction register.
REQ-004 SHALL have input Zero, 1 bit: ALU zero flag.
REQ-005 SHALL have input MemReady, 1 bit: memory access completes in the cycle it is 1.
REQ-006 SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite and RegWrite, each 1 bit.
REQ-007 SHALL have outputs ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0] and ImmSrc[1:0].
REQ-008 SHALL have output ALUControl[2:0] with encoding add=000, sub=001, and=010, or=011, slt=101.
REQ-009 SHALL have outputs Illegal (1 bit, one-cycle pulse) and State[3:0] (current state, for debug).

Function
REQ-010 SHALL implement a Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10.
REQ-011 SHALL drive every control output not listed for the current state to 0.
REQ-012 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
REQ-013 FETCH SHALL assert IRWrite and PCWrite only in a cycle with MemReady=1, then go to DECODE; with MemReady=0 it SHALL stay in FETCH.
REQ-014 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-015 DECODE SHALL branch on op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1101111 -> JAL, 1100011 -> BRANCH.
REQ-016 In DECODE, any other op SHALL pulse Illegal for 1 cycle and return the FSM to FETCH.
REQ-017 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state MEMREAD if op[5]=0, else MEMWRITE.
REQ-018 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00; it SHALL hold until MemReady=1, then go to MEMWB.
REQ-019 MEMWB SHALL drive ResultSrc=01, RegWrite=1; next state FETCH.
REQ-020 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1, with MemWrite held for every cycle until MemReady=1; then FETCH.
REQ-021 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; both go next to ALUWB.
REQ-022 ALUWB SHALL drive ResultSrc=00, RegWrite=1; next state FETCH.
REQ-023 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next state ALUWB.
REQ-024 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00 and PCWrite=Zero XOR funct3[0] (beq/bne); next state FETCH.
REQ-025 ALUControl SHALL be combinational from the internal ALUOp: 00 -> add, 01 -> sub.
REQ-026 For ALUOp=10, ALUControl SHALL decode funct3 as: 000 -> sub if (op[5] AND funct7b5) else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-027 ImmSrc SHALL be combinational from op in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.

Reset
REQ-028 reset=0 SHALL force State=FETCH immediately, independent of clk, and Illegal=0.
REQ-029 While reset=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0, overriding the FETCH decode; all other outputs SHALL take their FETCH values.
REQ-030 Reset asserted mid-instruction (including MEMWRITE) SHALL abort the instruction with no write strobe after assertion.
REQ-031 After reset deasserts, the first clk edge SHALL evaluate FETCH normally.

Verification
REQ-032 lw (op=0000011), MemReady tied 1 -> State 0,1,2,3,4,0; RegWrite=1 only in state 4; 5 cycles total.
REQ-033 sw (op=0100011), MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 for exactly 4 cycles, then FETCH.
REQ-034 R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; same in I-type (op=0010011) -> ALUControl=000.
REQ-035 beq with Zero=1 -> PCWrite=1 in BRANCH; bne (funct3=001) with Zero=1 -> PCWrite=0.
REQ-036 op=1111111 -> Illegal=1 for one cycle in DECODE, next State=0.
REQ-037 reset=0 pulsed asynchronously in MEMWRITE -> State=0 and MemWrite=0 before the next clk edge.
